// File: rtl/matrix_ram2d.sv
// ROWS x COLS register-file matrix with a synchronous write port, a registered read port
// and a one-entry-per-cycle clear sweep. Optional feature macro: MATRIX_RAM2D_TRANSPOSE_EN.
module matrix_ram2d #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int CNT_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    input  logic              transpose,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ROW_W:0]   ROWS_L   = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]   COLS_L   = (COL_W + 1)'(COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS * COLS - 1);

    logic [DATA_W-1:0] mem [ROWS][COLS];

    state_t            state;
    logic [CNT_W-1:0]  clr_cnt;
    logic [ROW_W-1:0]  clr_row;
    logic [COL_W-1:0]  clr_col;

    logic [ROW_W-1:0]  eff_row;
    logic [COL_W-1:0]  eff_col;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;

`ifdef MATRIX_RAM2D_TRANSPOSE_EN
    // Swapped indices are truncated to the destination field widths before range checking.
    always_comb begin
        eff_row = rd_row;
        eff_col = rd_col;
        if (transpose) begin
            eff_row = ROW_W'(rd_col);
            eff_col = COL_W'(rd_row);
        end
    end
`else
    logic unused_transpose;
    assign unused_transpose = transpose;
    assign eff_row = rd_row;
    assign eff_col = rd_col;
`endif

    assign wr_ok   = wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
    assign rd_ok   = ({1'b0, eff_row} < ROWS_L) && ({1'b0, eff_col} < COLS_L);
    assign rd_word = rd_ok ? mem[eff_row][eff_col] : '0;

    // Array contents are deliberately not reset; the sweep owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_row][clr_col] <= '0;
        end else if (wr_ok) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_row  <= '0;
            clr_col  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rd_data <= rd_word;
                    end
                    if (clr_req) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                        clr_row <= '0;
                        clr_col <= '0;
                    end
                end
                CLEAR: begin
                    rd_valid <= 1'b0;
                    if (clr_cnt == CNT_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        // Row/column walk alongside the linear count avoids a divider.
                        if (clr_col == COL_LAST) begin
                            clr_col <= '0;
                            clr_row <= clr_row + 1'b1;
                        end else begin
                            clr_col <= clr_col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_ram2d.sv
// Directed bench for matrix_ram2d: a default 4x4 instance and a 3x5 instance for
// non-power-of-two range handling.
module tb_matrix_ram2d;

    logic clk;
    logic rst_n;

    // 4x4 instance
    logic       wr_en, rd_en, transpose, clr_req;
    logic [1:0] wr_row, wr_col, rd_row, rd_col;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, busy, clr_done;

    // 3x5 instance
    logic       np_wr_en, np_rd_en, np_clr_req;
    logic [1:0] np_wr_row, np_rd_row;
    logic [2:0] np_wr_col, np_rd_col;
    logic [7:0] np_wr_data, np_rd_data;
    logic       np_rd_valid, np_busy, np_clr_done;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];

    matrix_ram2d dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .transpose(transpose),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    matrix_ram2d #(.DATA_W(8), .ROWS(3), .COLS(5)) dut_np (
        .clk(clk), .rst_n(rst_n),
        .wr_en(np_wr_en), .wr_row(np_wr_row), .wr_col(np_wr_col), .wr_data(np_wr_data),
        .rd_en(np_rd_en), .rd_row(np_rd_row), .rd_col(np_rd_col), .transpose(1'b0),
        .rd_data(np_rd_data), .rd_valid(np_rd_valid),
        .clr_req(np_clr_req), .busy(np_busy), .clr_done(np_clr_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [1:0] r, input logic [1:0] c,
                           input logic [7:0] exp);
        rd_en = 1'b1; rd_row = r; rd_col = c;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, int'(rd_valid), 1);
        check({tag, "_data"}, int'(rd_data), int'(exp));
    endtask

    task automatic np_write(input logic [1:0] r, input logic [2:0] c, input logic [7:0] d);
        np_wr_en = 1'b1; np_wr_row = r; np_wr_col = c; np_wr_data = d;
        tick();
        np_wr_en = 1'b0;
    endtask

    task automatic np_read(input string tag, input logic [1:0] r, input logic [2:0] c,
                           input logic [7:0] exp);
        np_rd_en = 1'b1; np_rd_row = r; np_rd_col = c;
        tick();
        np_rd_en = 1'b0;
        check({tag, "_valid"}, int'(np_rd_valid), 1);
        check({tag, "_data"}, int'(np_rd_data), int'(exp));
    endtask

    initial begin
        int n_busy;
        int n_pulse;
        logic [7:0] exp_v;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        wr_en = 0; rd_en = 0; transpose = 0; clr_req = 0;
        wr_row = 0; wr_col = 0; wr_data = 0; rd_row = 0; rd_col = 0;
        np_wr_en = 0; np_rd_en = 0; np_clr_req = 0;
        np_wr_row = 0; np_wr_col = 0; np_wr_data = 0; np_rd_row = 0; np_rd_col = 0;
        repeat (3) tick();
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clr_done", int'(clr_done), 0);
        rst_n = 1'b1;
        tick();

        // basic write then read, read latency one cycle
        do_write(2'd2, 2'd3, 8'hA5);
        do_read("basic", 2'd2, 2'd3, 8'hA5);
        tick();
        check("hold_valid", int'(rd_valid), 0);
        check("hold_data", int'(rd_data), 'hA5);

        // read-first collision
        do_write(2'd1, 2'd1, 8'h11);
        wr_en = 1; wr_row = 2'd1; wr_col = 2'd1; wr_data = 8'h22;
        rd_en = 1; rd_row = 2'd1; rd_col = 2'd1;
        tick();
        wr_en = 0; rd_en = 0;
        check("coll_old", int'(rd_data), 'h11);
        do_read("coll_new", 2'd1, 2'd1, 8'h22);

        // back-to-back reads
        do_write(2'd0, 2'd0, 8'h01);
        rd_en = 1; rd_row = 2'd0; rd_col = 2'd0;
        tick();
        check("b2b_0", int'(rd_data), 'h01);
        rd_row = 2'd2; rd_col = 2'd3;
        tick();
        rd_en = 0;
        check("b2b_1", int'(rd_data), 'hA5);
        check("b2b_1_valid", int'(rd_valid), 1);

        // transpose
        do_write(2'd3, 2'd0, 8'h55);
        do_write(2'd0, 2'd3, 8'h7E);
        transpose = 1'b1;
`ifdef MATRIX_RAM2D_TRANSPOSE_EN
        do_read("transpose", 2'd3, 2'd0, 8'h7E);
`else
        do_read("transpose", 2'd3, 2'd0, 8'h55);
`endif
        transpose = 1'b0;

        // clear sweep on full array
        for (int i = 0; i < 16; i++) begin
            do_write(2'(i / 4), 2'(i % 4), 8'(i + 8'h80));
        end
        do_read("pre_clr", 2'd3, 2'd3, 8'h8F);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n_busy = 0;
        n_pulse = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n_busy++;
            if (clr_done) n_pulse++;
            if (rd_valid) n_pulse += 100;
            wr_en = 1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hFF;
            rd_en = 1; rd_row = 2'd3; rd_col = 2'd3;
            tick();
        end
        wr_en = 0; rd_en = 0;
        check("clr_busy_cycles", n_busy, 16);
        check("clr_quiet_during", n_pulse, 0);
        check("clr_done_pulse", int'(clr_done), 1);
        tick();
        check("clr_done_one_cycle", int'(clr_done), 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 16; i++) begin
            exp_v = exp_q.pop_front();
            do_read($sformatf("clr_rd%0d", i), 2'(i / 4), 2'(i % 4), exp_v);
        end

        // write and clear request in the same cycle: the sweep wins
        wr_en = 1; wr_row = 2'd1; wr_col = 2'd2; wr_data = 8'h6A; clr_req = 1;
        tick();
        wr_en = 0; clr_req = 0;
        for (int i = 0; i < 40 && busy; i++) tick();
        check("wr_clr_busy_end", int'(busy), 0);
        do_read("wr_clr", 2'd1, 2'd2, 8'h00);

        // reset mid-sweep
        do_write(2'd0, 2'd1, 8'h99);
        do_read("pre_rst", 2'd0, 2'd1, 8'h99);
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (5) tick();
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_valid", int'(rd_valid), 0);
        check("rst_mid_data", int'(rd_data), 0);
        check("rst_mid_done", int'(clr_done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", int'(busy), 0);
        do_write(2'd0, 2'd0, 8'h3C);
        do_read("post_rst", 2'd0, 2'd0, 8'h3C);

        // 3x5 instance: range checks and sweep length
        np_write(2'd2, 3'd4, 8'h6D);
        np_write(2'd3, 3'd0, 8'h44);
        np_write(2'd0, 3'd5, 8'h45);
        np_read("np_last", 2'd2, 3'd4, 8'h6D);
        np_read("np_row3", 2'd3, 3'd0, 8'h00);
        np_read("np_col5", 2'd0, 3'd5, 8'h00);
        np_clr_req = 1;
        tick();
        np_clr_req = 0;
        n_busy = 0;
        for (int i = 0; i < 40 && np_busy; i++) begin
            n_busy++;
            tick();
        end
        check("np_clr_cycles", n_busy, 15);
        check("np_clr_done", int'(np_clr_done), 1);
        np_read("np_after_clr", 2'd2, 3'd4, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_ram2d.md
# matrix_ram2d

Parametrised two-dimensional register-file memory of ROWS x COLS words, DATA_W bits each, addressed by separate row and column indices. It provides a synchronous write port, a registered read port with a valid flag, and a hardware clear sequencer that zeroes the whole array one entry per cycle. It sits beside datapath blocks as a small scratch matrix store.

## Interface
- DATA_W, 8, word width in bits (>=1)
- ROWS, 4, number of rows (>=1, need not be a power of two)
- COLS, 4, number of columns (>=1, need not be a power of two)
- Derived: ROW_W = max(1, $clog2(ROWS)); COL_W = max(1, $clog2(COLS)); CNT_W = max(1, $clog2(ROWS*COLS))

- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_row  in  ROW_W  write row index
- wr_col  in  COL_W  write column index
- wr_data  in  DATA_W  write data
- rd_en  in  1  read strobe
- rd_row  in  ROW_W  read row index
- rd_col  in  COL_W  read column index
- transpose  in  1  swap read indices (effective only with MATRIX_RAM2D_TRANSPOSE_EN)
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated this cycle
- clr_req  in  1  start clear sweep (level sampled, acted on in IDLE)
- busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse after the last entry is cleared

## Operation
- Reset values: rd_data=0, rd_valid=0, busy=0, clr_done=0, FSM=IDLE, sweep counter=0. Array contents are not reset.
- Write: in IDLE with wr_en=1 and wr_row<ROWS and wr_col<COLS, the entry is written at the clock edge. Out-of-range writes are dropped.
- Read: in IDLE with rd_en=1, rd_data<=entry, rd_valid<=1. An out-of-range index returns 0 with rd_valid=1.
- Without rd_en, rd_valid<=0 and rd_data holds its value.
- Same-address read and write in one cycle: read-first, so rd_data returns the old contents.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, counter<=0, busy<=1.
  - CLEAR: writes 0 to entry (counter/COLS, counter%COLS) each cycle and increments the counter. At counter=ROWS*COLS-1 it goes to IDLE, busy<=0 and clr_done<=1 for one cycle.
- During CLEAR, wr_en, rd_en and clr_req are ignored, and rd_valid stays 0.
- wr_en and clr_req in the same IDLE cycle: the write is performed, then the sweep clears it.
- Reset asserted mid-sweep: aborts immediately to IDLE. Array contents are then unspecified. The bench must not rely on them.

## Timing
- Write latency: visible to a read issued the following cycle.
- Read latency: 1 cycle (rd_en at edge N -> rd_data/rd_valid valid after edge N).
- Clear: busy rises the edge after clr_req is sampled. It stays high exactly ROWS*COLS cycles, and clr_done pulses on the edge busy falls.
- A new operation is accepted in the cycle busy is low.
- Back-to-back reads give one result per cycle.

## Configuration
- MATRIX_RAM2D_TRANSPOSE_EN defined: when transpose=1, the read addresses entry [rd_col][rd_row]. Both indices are range-checked against ROWS/COLS after the swap, and out of range returns 0. This is meaningful when ROWS=COLS. With a non-square array, indices are truncated to the swapped field widths.
- Undefined: the transpose port exists but is ignored, and reads always use [rd_row][rd_col].

## Test plan
- Basic R/W, default params: write 0xA5 to [2][3], read [2][3] next cycle -> rd_data=0xA5, rd_valid=1 one cycle after rd_en.
- Read-first collision: [1][1]=0x11. In one cycle, write 0x22 and read [1][1] -> rd_data=0x11. The next read -> 0x22.
- Clear sweep: fill all 16 entries with nonzero data, pulse clr_req. busy is high for 16 cycles, and writes/reads issued meanwhile have no effect (rd_valid=0). clr_done pulses once, then all reads return 0x00.
- Non-power-of-two (ROWS=3, COLS=5): write to row 3 is dropped. Read row 3 -> rd_data=0, rd_valid=1. Clear takes 15 cycles.
- Reset mid-clear: assert rst_n=0 at sweep cycle 5 -> busy, rd_valid, rd_data and clr_done are 0 immediately. After release, the FSM is IDLE and a write/read of [0][0]=0x3C returns 0x3C.
- With MATRIX_RAM2D_TRANSPOSE_EN: write 0x7E to [0][3], read rd_row=3, rd_col=0 with transpose=1 -> 0x7E. Without the macro, the same read returns the [3][0] contents.
